ps2_scan_rx: RTL and testbench
==============================

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth on ps2_clk and ps2_data, legal range 2..4.
REQ-002 Parameter FIFO_DEPTH, default 8: scan-code FIFO entries, power of two, legal range 2..64.
REQ-003 Parameter TIMEOUT_CYCLES, default 5000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-007 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-008 rd_en  input  1  pops the FIFO head when valid=1.
REQ-009 code  output  8  scan code at the FIFO head.
REQ-010 ext  output  1  head code was preceded by E0.
REQ-011 brk  output  1  head code was preceded by F0 (key release).
REQ-012 valid  output  1  FIFO not empty.
REQ-013 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-014 overflow  output  1  one-cycle pulse: a decoded code was dropped because the FIFO was full.
REQ-015 parity_err  output  1  one-cycle pulse: frame rejected on parity.
REQ-016 frame_err  output  1  one-cycle pulse: frame rejected on stop bit=0 or timeout.

Function
REQ-017 ps2_clk and ps2_data SHALL each pass through SYNC_STAGES flops reset to 1; a sample event is a synchronised ps2_clk 1->0 transition, with data taken from synchronised ps2_data in the same cycle.
REQ-018 Frame FSM SHALL have states IDLE, DATA, PARITY, STOP; on a sample event: IDLE->DATA when data=0, IDLE stays when data=1; DATA shifts 8 bits LSB first, ->PARITY after bit 8; PARITY->STOP; STOP->IDLE.
REQ-019 A frame SHALL be accepted only when data bits plus parity bit have odd parity and stop bit=1; on parity failure pulse parity_err; on stop=0 with good parity pulse frame_err; parity failure takes precedence over stop failure (parity_err only).
REQ-020 A timeout counter SHALL clear on every sample event and in IDLE; outside IDLE, when it reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE and pulse frame_err.
REQ-021 Accepted byte E0 SHALL set ext_pending; F0 SHALL set brk_pending; neither is pushed.
REQ-022 Any other accepted byte SHALL push {ext_pending, brk_pending, byte} on the cycle after the stop sample and clear both pendings; valid rises the following cycle.
REQ-023 parity_err or frame_err SHALL clear both pendings.
REQ-024 FIFO SHALL be show-ahead: code/ext/brk reflect the head while valid=1 and are 0 while empty.
REQ-025 rd_en with valid=0 SHALL be ignored; push while full without a simultaneous pop SHALL drop the entry and pulse overflow.
REQ-026 Push and pop in the same cycle SHALL both take effect, including when full (no overflow) and when holding one entry.
REQ-027 Occupancy SHALL be held in a counter of clog2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 rst_n low SHALL asynchronously force: FSM IDLE, shift register, bit and timeout counters, pendings, FIFO pointers and count to 0; synchronisers to 1; all outputs to 0.
REQ-029 Reset assertion mid-frame SHALL discard the partial frame; after deassertion, reception resumes at the next start bit.

Structure
REQ-030 A shared package ps2_pkg SHALL hold the FSM state enum, constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0, and the 10-bit FIFO entry type.
REQ-031 FIFO storage SHALL be one sub-module, sync_fifo, parametrised on width and depth.

Verification
REQ-032 Frame 0x1C (parity 0, stop 1) -> valid rises, code=0x1C, ext=0, brk=0; rd_en -> valid=0.
REQ-033 Frames F0, 1C -> one entry: code=0x1C, brk=1, ext=0; frames E0, F0, 75 -> code=0x75, ext=1, brk=1.
REQ-034 Frame 0x16 with wrong parity bit -> parity_err pulse, no push; following F0 frame with parity error, then 0x16 -> brk=0.
REQ-035 Four bits then idle for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next valid frame 0x45 decoded correctly.
REQ-036 FIFO_DEPTH+1 codes with rd_en=0 -> full=1, one overflow pulse, first FIFO_DEPTH codes read in order; rd_en held while a push lands at full -> no overflow.
REQ-037 rst_n low during bit 5 -> all outputs 0; next complete frame 0x1B decoded correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scan-code receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  localparam int PS2_ENTRY_W = $bits(ps2_entry_t);

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy counter and overflow pulse
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign valid = (count != '0);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign pop   = rd_en & valid;
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign push  = wr_en & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= wr_en & full & ~pop;
    end
  end

  assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix folding and scan-code FIFO
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] code,
  output logic       ext,
  output logic       brk,
  output logic       valid,
  output logic       full,
  output logic       overflow,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   sample;
  logic                   bit_in;

  ps2_state_t state;
  ps2_state_t state_nxt;
  logic       frame_end;
  logic       timed_out;

  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;
  logic          par_ok;

  logic       byte_rdy;
  logic [7:0] byte_q;
  logic       ext_pending;
  logic       brk_pending;
  logic       push;
  ps2_entry_t wr_entry;
  logic [PS2_ENTRY_W-1:0] head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign sample = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];
  assign par_ok = odd_parity_ok(shift_reg, parity_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    timed_out = 1'b0;
    if (sample) begin
      case (state)
        ST_IDLE:   if (!bit_in) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP: begin
          state_nxt = ST_IDLE;
          frame_end = 1'b1;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && tmo_cnt == TMO_LAST) begin
      state_nxt = ST_IDLE;
      timed_out = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      if (sample || state == ST_IDLE || timed_out) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (sample && state == ST_DATA) begin
        shift_reg <= {bit_in, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end else if (state == ST_IDLE || timed_out) begin
        bit_cnt <= '0;
      end
      if (sample && state == ST_PARITY) begin
        parity_bit <= bit_in;
      end
    end
  end

  // Frame verdict is registered; a good byte is folded into the FIFO one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_rdy    <= 1'b0;
      byte_q      <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
    end else begin
      byte_rdy   <= frame_end & par_ok & bit_in;
      byte_q     <= shift_reg;
      parity_err <= frame_end & ~par_ok;
      frame_err  <= (frame_end & par_ok & ~bit_in) | timed_out;
      if (parity_err || frame_err) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (byte_rdy) begin
        if (byte_q == PS2_EXT) begin
          ext_pending <= 1'b1;
        end else if (byte_q == PS2_BRK) begin
          brk_pending <= 1'b1;
        end else begin
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
        end
      end
    end
  end

  assign push     = byte_rdy && byte_q != PS2_EXT && byte_q != PS2_BRK;
  assign wr_entry = '{ext: ext_pending, brk: brk_pending, code: byte_q};

  sync_fifo #(
    .WIDTH(PS2_ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push),
    .wr_data  (wr_entry),
    .rd_en    (rd_en),
    .rd_data  (head),
    .valid    (valid),
    .full     (full),
    .overflow (overflow)
  );

  assign {ext, brk, code} = head;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb/tb_ps2_scan_rx.sv - self-checking bench for ps2_scan_rx
module tb_ps2_scan_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 400;
  localparam int HP    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] code;
  logic       ext, brk, valid, full, overflow, parity_err, frame_err;

  ps2_scan_rx #(
    .SYNC_STAGES(2),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .code       (code),
    .ext        (ext),
    .brk        (brk),
    .valid      (valid),
    .full       (full),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int fall_cyc = 0;
  int ovf_cyc = -1;
  int n_perr = 0, n_ferr = 0, n_ovf = 0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (overflow) begin
      n_ovf++;
      ovf_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad, input logic stop);
    return {stop, (~^b) ^ bad, b, 1'b0};
  endfunction

  // Bits go out LSB first; rd_at>0 raises rd_en for one cycle rd_at-1 cycles after the last fall.
  task automatic send_bits(input logic [10:0] bits, input int n, input int rd_at);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1 ps2_data = bits[k];
      repeat (HP) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (k == n - 1) fall_cyc = cyc;
      for (int i = 0; i < HP; i++) begin
        @(posedge clk); #1;
        if (rd_at > 0 && k == n - 1) rd_en = (i + 1 == rd_at - 1);
      end
      ps2_clk = 1'b1;
    end
    rd_en = 1'b0;
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (HP) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad, input logic stop, input int rd_at);
    send_bits(mk_frame(b, bad, stop), 11, rd_at);
  endtask

  task automatic pop_check(input string name, input logic [7:0] c, input logic e, input logic k);
    @(negedge clk);
    chk({name, "_valid"}, valid, 1);
    chk({name, "_entry"}, {ext, brk, code}, {e, k, c});
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Frame-level reference: prefixes fold into the next ordinary code, errors drop them.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ent_t;
  ent_t mq[$];
  bit   m_ext, m_brk;
  int   m_perr, m_ferr, m_ovf;

  task automatic model_frame(input logic [7:0] b, input bit bad, input bit stop);
    if (bad) begin
      m_perr++;
      m_ext = 0; m_brk = 0;
    end else if (!stop) begin
      m_ferr++;
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (mq.size() == DEPTH) m_ovf++;
      else mq.push_back('{ext: m_ext, brk: m_brk, code: b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         stop;
    bit         push;
    logic [7:0] code;
    bit         ext;
    bit         brk;
    int         perr;
    int         ferr;
  } vec_t;

  vec_t vt[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int p0, f0, o0, lat;
    logic [7:0] rb;
    bit rbad, rstop;

    vt[0]  = '{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0, 0};
    vt[1]  = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0, 0};
    vt[2]  = '{8'h1C, 0, 1, 1, 8'h1C, 0, 1, 0, 0};
    vt[3]  = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0, 0};
    vt[4]  = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0, 0};
    vt[5]  = '{8'h75, 0, 1, 1, 8'h75, 1, 1, 0, 0};
    vt[6]  = '{8'h16, 1, 1, 0, 8'h00, 0, 0, 1, 0};
    vt[7]  = '{8'hF0, 1, 1, 0, 8'h00, 0, 0, 1, 0};
    vt[8]  = '{8'h16, 0, 1, 1, 8'h16, 0, 0, 0, 0};
    vt[9]  = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0, 0};
    vt[10] = '{8'h22, 0, 0, 0, 8'h00, 0, 0, 0, 1};
    vt[11] = '{8'h22, 0, 1, 1, 8'h22, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", {code, ext, brk, valid, full, overflow, parity_err, frame_err}, 0);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_reset_outputs", {code, ext, brk, valid, full, overflow, parity_err, frame_err}, 0);

    for (int v = 0; v < 12; v++) begin
      p0 = n_perr;
      f0 = n_ferr;
      send_frame(vt[v].b, vt[v].bad, vt[v].stop, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_perr", v), n_perr - p0, vt[v].perr);
      chk($sformatf("vec%0d_ferr", v), n_ferr - f0, vt[v].ferr);
      chk($sformatf("vec%0d_valid", v), valid, vt[v].push);
      if (vt[v].push) begin
        pop_check($sformatf("vec%0d", v), vt[v].code, vt[v].ext, vt[v].brk);
        @(negedge clk);
        chk($sformatf("vec%0d_empty_after_pop", v), valid, 0);
      end
    end

    // Partial frame abandoned by timeout, then a clean frame.
    p0 = n_perr;
    f0 = n_ferr;
    send_bits(mk_frame(8'h45, 0, 1), 5, 0);
    repeat (TMO + 20) @(posedge clk);
    @(negedge clk);
    chk("timeout_ferr", n_ferr - f0, 1);
    chk("timeout_perr", n_perr - p0, 0);
    chk("timeout_no_push", valid, 0);
    send_frame(8'h45, 0, 1, 0);
    pop_check("after_timeout", 8'h45, 0, 0);

    // Overflow: DEPTH+1 codes without reading.
    o0 = n_ovf;
    ovf_cyc = -1;
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h30 + 8'(i), 0, 1, 0);
    @(negedge clk);
    chk("ovf_full", full, 1);
    chk("ovf_pulses", n_ovf - o0, 1);
    lat = (ovf_cyc >= 0) ? ovf_cyc - fall_cyc : 4;
    if (lat < 2 || lat > HP) lat = 4;
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovf_order%0d", i), 8'h30 + 8'(i), 0, 0);
    @(negedge clk);
    chk("ovf_drained", valid, 0);

    // Push landing on a full FIFO together with a pop.
    for (int i = 0; i < DEPTH; i++) send_frame(8'h50 + 8'(i), 0, 1, 0);
    o0 = n_ovf;
    send_frame(8'h5F, 0, 1, lat);
    @(negedge clk);
    chk("pushpop_full_no_ovf", n_ovf - o0, 0);
    chk("pushpop_still_full", full, 1);
    for (int i = 1; i < DEPTH; i++) pop_check($sformatf("pushpop%0d", i), 8'h50 + 8'(i), 0, 0);
    pop_check("pushpop_last", 8'h5F, 0, 0);

    // Reset in the middle of a frame while an entry is held.
    send_frame(8'h2A, 0, 1, 0);
    @(negedge clk);
    chk("pre_reset_valid", valid, 1);
    send_bits(mk_frame(8'h1B, 0, 1), 6, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    chk("midframe_reset_outputs", {code, ext, brk, valid, full, overflow, parity_err, frame_err}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(8'h1B, 0, 1, 0);
    pop_check("after_reset", 8'h1B, 0, 0);
    @(negedge clk);
    chk("after_reset_empty", valid, 0);

    // Randomised frames against the frame-level model.
    do_reset();
    mq.delete();
    m_ext = 0; m_brk = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
    p0 = n_perr;
    f0 = n_ferr;
    o0 = n_ovf;
    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        default: ;
      endcase
      rbad  = ($urandom_range(0, 9) == 0);
      rstop = ($urandom_range(0, 14) != 0);
      send_frame(rb, rbad, rstop, 0);
      model_frame(rb, rbad, rstop);
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        if (mq.size() > 0) begin
          ent_t e;
          e = mq.pop_front();
          pop_check($sformatf("rnd%0d", n), e.code, e.ext, e.brk);
        end
      end
      @(negedge clk);
      chk($sformatf("rnd%0d_valid", n), valid, (mq.size() > 0) ? 1 : 0);
    end
    while (mq.size() > 0) begin
      ent_t e;
      e = mq.pop_front();
      pop_check("rnd_drain", e.code, e.ext, e.brk);
    end
    @(negedge clk);
    chk("rnd_drained", valid, 0);
    chk("rnd_perr_count", n_perr - p0, m_perr);
    chk("rnd_ferr_count", n_ferr - f0, m_ferr);
    chk("rnd_ovf_count", n_ovf - o0, m_ovf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
